pipe_hazard_ctrl: RTL

Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable and clear strobes for load-use stalls, branch/jump redirect flushes, and syscall halt/resume.
- Generates forwarding selects for the EX-stage operands.
- Maintains cycle, stall and flush statistics counters for the CCMB display.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/hazard_fwd_unit.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Covers the sequencer state and the EX-operand forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detector and EX-stage operand forwarding selects.
// MEM has priority over WB, and register 0 is never a forwarding source.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_wr,
    input  logic [REG_W-1:0] wb_rd,
    output logic             load_use,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_wr && (mem_rd != '0) && (mem_rd == src))
            return FWD_MEM;
        else if (wb_wr && (wb_rd != '0) && (wb_rd == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        load_use = ex_load && ex_wr && (ex_rd != '0) &&
                   ((id_use_rs && (id_rs == ex_rd)) ||
                    (id_use_rt && (id_rt == ex_rd)));
        fwd_a    = fwd_sel(ex_rs);
        fwd_b    = fwd_sel(ex_rt);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RUN/HALT/RESUME FSM, per-stage enable/clear strobes,
// forwarding selects and cycle/stall/flush statistics counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             in_CLK,
    input  logic             in_CLR,
    input  logic             in_go,
    input  logic [REG_W-1:0] in_id_rs,
    input  logic [REG_W-1:0] in_id_rt,
    input  logic             in_id_use_rs,
    input  logic             in_id_use_rt,
    input  logic [REG_W-1:0] in_ex_rs,
    input  logic [REG_W-1:0] in_ex_rt,
    input  logic             in_ex_wr,
    input  logic [REG_W-1:0] in_ex_rd,
    input  logic             in_ex_load,
    input  logic             in_ex_redirect,
    input  logic             in_mem_wr,
    input  logic [REG_W-1:0] in_mem_rd,
    input  logic             in_wb_wr,
    input  logic [REG_W-1:0] in_wb_rd,
    input  logic             in_wb_halt,
    output logic             out_pc_en,
    output logic             out_ifid_en,
    output logic             out_idex_en,
    output logic             out_exmem_en,
    output logic             out_memwb_en,
    output logic             out_ifid_clr,
    output logic             out_idex_clr,
    output logic [1:0]       out_fwd_a,
    output logic [1:0]       out_fwd_b,
    output logic             out_halted,
    output logic [CNT_W-1:0] out_cycles,
    output logic [CNT_W-1:0] out_stalls,
    output logic [CNT_W-1:0] out_flushes
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, next_state;
    logic       load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       count_en, stall, flush;

    hazard_fwd_unit #(.REG_W(REG_W)) u_hazard_fwd (
        .id_rs     (in_id_rs),
        .id_rt     (in_id_rt),
        .id_use_rs (in_id_use_rs),
        .id_use_rt (in_id_use_rt),
        .ex_rs     (in_ex_rs),
        .ex_rt     (in_ex_rt),
        .ex_wr     (in_ex_wr),
        .ex_rd     (in_ex_rd),
        .ex_load   (in_ex_load),
        .mem_wr    (in_mem_wr),
        .mem_rd    (in_mem_rd),
        .wb_wr     (in_wb_wr),
        .wb_rd     (in_wb_rd),
        .load_use  (load_use),
        .fwd_a     (fwd_a_raw),
        .fwd_b     (fwd_b_raw)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state   = state;
        out_pc_en    = 1'b0;
        out_ifid_en  = 1'b0;
        out_idex_en  = 1'b0;
        out_exmem_en = 1'b0;
        out_memwb_en = 1'b0;
        out_ifid_clr = 1'b0;
        out_idex_clr = 1'b0;
        count_en     = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;

        if (!in_CLR) begin
            case (state)
                HALT: begin
                    if (in_go)
                        next_state = RESUME;
                end
                default: begin
                    count_en     = 1'b1;
                    out_pc_en    = 1'b1;
                    out_ifid_en  = 1'b1;
                    out_idex_en  = 1'b1;
                    out_exmem_en = 1'b1;
                    out_memwb_en = 1'b1;
                    // A redirect squashes the dependent instruction, so it overrides the stall.
                    if (in_ex_redirect) begin
                        flush        = 1'b1;
                        out_ifid_clr = 1'b1;
                        out_idex_clr = 1'b1;
                    end else if (load_use) begin
                        stall        = 1'b1;
                        out_pc_en    = 1'b0;
                        out_ifid_en  = 1'b0;
                        out_idex_clr = 1'b1;
                    end
                    // RESUME ignores the syscall still frozen in WB.
                    next_state = (state == RUN && in_wb_halt) ? HALT : RUN;
                end
            endcase
        end
    end

    assign out_fwd_a = in_CLR ? FWD_RF : fwd_a_raw;
    assign out_fwd_b = in_CLR ? FWD_RF : fwd_b_raw;

    // NOTE: reset is synchronous, so it is sampled inside the clocked block; state uses <= only.
    always_ff @(posedge in_CLK) begin
        if (in_CLR) begin
            state       <= RUN;
            out_halted  <= 1'b0;
            out_cycles  <= '0;
            out_stalls  <= '0;
            out_flushes <= '0;
        end else begin
            state      <= next_state;
            out_halted <= (next_state == HALT);
            if (count_en) out_cycles  <= out_cycles + CNT_ONE;
            if (stall)    out_stalls  <= out_stalls + CNT_ONE;
            if (flush)    out_flushes <= out_flushes + CNT_ONE;
        end
    end

endmodule
